fdiv_arbiter: RTL and testbench



---
 rtl/fdiv_arbiter.sv | 144 ++++++++++++++
 tb/tb_fdiv_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipelined divider between
// NREQ requesters. Results are returned through a credit-protected response FIFO.
module fdiv_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  LATENCY = 6,
    parameter int  DEPTH   = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_op1,
    input  logic [32*NREQ-1:0]   req_op2,
    output logic [31:0]          div_op1,
    output logic [31:0]          div_op2,
    input  logic [31:0]          div_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data,
    output logic                 busy
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  last_ptr;

    logic [LATENCY-1:0] tag_v_q;
    logic [IDW-1:0]     tag_id_q   [LATENCY];
    logic [IDW-1:0]     mem_id_q   [DEPTH];
    logic [31:0]        mem_data_q [DEPTH];

    logic           can_issue, grant_vld, push, pop;
    logic [IDW-1:0] grant_id, cand;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered counts only, so a pop frees its slot one cycle later.
    assign can_issue = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CREDITS;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        if (reset || !can_issue) begin
            grant_vld = 1'b0;
            grant_id  = '0;
        end
    end

    assign req_ready = grant_vld ? (NREQ'(1) << grant_id) : '0;
    assign div_op1   = grant_vld ? req_op1[32*int'(grant_id) +: 32] : '0;
    assign div_op2   = grant_vld ? req_op2[32*int'(grant_id) +: 32] : '0;

    assign push       = tag_v_q[LATENCY-1];
    assign resp_valid = (fifo_cnt_q != '0);
    assign pop        = resp_valid & resp_ready;
    assign busy       = (inflight_q != '0) || (fifo_cnt_q != '0);

    // When empty, the slot just behind the read pointer still holds the last head.
    assign last_ptr  = (rd_ptr_q == '0) ? PW'(DEPTH - 1) : rd_ptr_q - PW'(1);
    assign resp_id   = resp_valid ? mem_id_q[rd_ptr_q]   : mem_id_q[last_ptr];
    assign resp_data = resp_valid ? mem_data_q[rd_ptr_q] : mem_data_q[last_ptr];

    always_comb begin
        rr_ptr_d   = grant_vld ? grant_id : rr_ptr_q;
        inflight_d = inflight_q;
        if (grant_vld && !push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!grant_vld && push) begin
            inflight_d = inflight_q - CW'(1);
        end
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= IDW'(NREQ - 1);
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (push) begin
                assert (fifo_cnt_q != CW'(DEPTH));
            end
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q     <= {tag_v_q[LATENCY-2:0], grant_vld};
            tag_id_q[0] <= grant_id;
            for (int k = 1; k < LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_id_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push) begin
            mem_id_q[wr_ptr_q]   <= tag_id_q[LATENCY-1];
            mem_data_q[wr_ptr_q] <= div_result;
        end
    end
endmodule

// File: tb/tb_fdiv_arbiter.sv
// Bench for fdiv_arbiter: directed and random traffic checked against a transaction
// model (outstanding queue for credit and order, round-robin pick, fixed latency).
module tb_fdiv_arbiter;
    localparam int NREQ    = 4;
    localparam int LATENCY = 6;
    localparam int DEPTH   = 8;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_op1, req_op2;
    logic [31:0]         div_op1, div_op2, div_result;
    logic                resp_valid, resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_data;
    logic                busy;

    always #5 clk = ~clk;

    fdiv_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .div_op1(div_op1), .div_op2(div_op2),
        .div_result(div_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    // Stand-in divider: known float quotients, otherwise a deterministic scramble.
    function automatic logic [31:0] dmodel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        if (a == 32'hC1100000 && b == 32'h40400000) return 32'hC0400000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h13579BDF;
    endfunction

    logic [31:0] dpipe [LATENCY];
    always @(posedge clk) begin
        dpipe[0] <= dmodel(div_op1, div_op2);
        for (int k = 1; k < LATENCY; k++) dpipe[k] <= dpipe[k-1];
    end
    assign div_result = dpipe[LATENCY-1];

    typedef struct {
        int          id;
        logic [31:0] data;
        int          t;
    } resp_t;

    resp_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rr_m;
    int          last_id;
    logic [31:0] last_data;
    bit          auto_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_op1[32*i +: 32] = a;
        req_op2[32*i +: 32] = b;
        req_valid[i]        = 1'b1;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        int              g;
        logic [NREQ-1:0] er;
        logic [31:0]     e1, e2;
        bit              hv;
        #1;
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
            end
        end
        er = '0;
        e1 = '0;
        e2 = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            e1    = req_op1[32*g +: 32];
            e2    = req_op2[32*g +: 32];
        end
        hv = (exp_q.size() != 0) && (exp_q[0].t + LATENCY + 1 <= cyc);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("div_op1", div_op1, e1);
        chk("div_op2", div_op2, e2);
        chk("resp_valid", 32'(resp_valid), 32'(hv));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (hv) begin
            chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
            chk("resp_data", resp_data, exp_q[0].data);
        end else begin
            chk("hold_id", 32'(resp_id), 32'(last_id));
            chk("hold_data", resp_data, last_data);
        end
        @(posedge clk);
        if (hv && resp_ready) begin
            last_id   = exp_q[0].id;
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        if (g >= 0) begin
            exp_q.push_back('{g, dmodel(e1, e2), cyc});
            rr_m = g;
        end
        cyc++;
        @(negedge clk);
        if (auto_drop && g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        rr_m      = NREQ - 1;
        last_id   = 0;
        last_data = '0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        resp_ready = 1'b0;
        auto_drop  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_div_op1", div_op1, 32'h0);
        chk("rst_div_op2", div_op2, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // single request, 6.0 / 2.0
        resp_ready = 1'b1;
        set_req(0, 32'h40C00000, 32'h40000000);
        tick();
        repeat (10) tick();

        // all requesters continuously valid
        auto_drop = 1'b0;
        set_req(0, 32'h40C00000, 32'h40000000);
        set_req(1, 32'h3F800000, 32'h40800000);
        set_req(2, 32'hC1100000, 32'h40400000);
        set_req(3, 32'h41200000, 32'h40A00000);
        repeat (20) tick();
        req_valid = '0;
        repeat (10) tick();

        // credit limit with consumer stalled
        resp_ready = 1'b0;
        set_req(1, 32'h3F800000, 32'h40800000);
        repeat (16) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        repeat (4) tick();
        auto_drop  = 1'b1;
        resp_ready = 1'b1;
        repeat (20) tick();

        // FIFO at three entries, push and pop in the same cycle
        resp_ready = 1'b0;
        set_req(0, 32'h11111111, 32'h22222222);
        tick();
        set_req(2, 32'h33333333, 32'h44444444);
        tick();
        set_req(3, 32'h55555555, 32'h66666666);
        tick();
        repeat (7) tick();
        set_req(1, 32'h77777777, 32'h88888888);
        tick();
        repeat (5) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        repeat (2) tick();
        resp_ready = 1'b1;
        repeat (8) tick();

        // asynchronous reset with results in flight and buffered
        resp_ready = 1'b0;
        set_req(0, 32'h40C00000, 32'h40000000);
        tick();
        set_req(1, 32'h3F800000, 32'h40800000);
        tick();
        repeat (6) tick();
        set_req(0, 32'h01020304, 32'h05060708);
        set_req(1, 32'h090A0B0C, 32'h0D0E0F10);
        set_req(2, 32'hC1100000, 32'h40400000);
        set_req(3, 32'hDEADBEEF, 32'h12345678);
        repeat (4) tick();
        #3 reset = 1'b1;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_resp_data", resp_data, 32'h0);
        model_reset();
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * LATENCY + 2) tick();

        // idle cycles must not move the round-robin pointer
        resp_ready = 1'b1;
        set_req(2, 32'hC1100000, 32'h40400000);
        tick();
        repeat (3) tick();
        set_req(0, 32'h40C00000, 32'h40000000);
        set_req(3, 32'h41200000, 32'h40A00000);
        #1;
        chk("rr_after_idle", 32'(req_ready), 32'h8);
        tick();
        repeat (10) tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 32'hC1100000, 32'h40400000);
                    else set_req(i, $urandom, $urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        resp_ready = 1'b1;
        repeat (60) tick();
        #1;
        chk("drain_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
